// File: rtl/if_id_stage.sv
// Fetch front end: PC/nPC pair with delayed branching, the imem address, and the IF/ID register.
// Honours hazard stalls and ID-stage redirect/annul; a saturating counter records stall cycles.
module if_id_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               annul,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] instr_id,
  output logic [ADDR_W-1:0]  pc_id,
  output logic [ADDR_W-1:0]  npc_id,
  output logic               nop_id,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] RESET_NPC = RESET_PC + PC_STEP;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    npc_q, npc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]    pc_id_q, pc_id_d;
  logic [ADDR_W-1:0]    npc_id_q, npc_id_d;
  logic                 nop_q, nop_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Sequential successor wraps modulo 2^ADDR_W by construction.
  logic [ADDR_W-1:0]    seq_npc;
  assign seq_npc = npc_q + PC_STEP;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    npc_d    = npc_q;
    instr_d  = instr_q;
    pc_id_d  = pc_id_q;
    npc_id_d = npc_id_q;
    nop_d    = nop_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_BOOT: begin
        state_d  = ST_RUN;
        instr_d  = '0;
        pc_id_d  = '0;
        npc_id_d = '0;
        nop_d    = 1'b1;
      end
      ST_RUN: begin
        if (stall) begin
          // ID is frozen too, so any redirect is re-presented once the stall lifts.
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          pc_id_d  = pc_q;
          npc_id_d = npc_q;
          if (annul) begin
            instr_d = '0;
            nop_d   = 1'b1;
          end else begin
            instr_d = imem_data;
            nop_d   = 1'b0;
          end
          pc_d  = npc_q;
          npc_d = br_taken ? br_target : seq_npc;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      npc_q    <= RESET_NPC;
      instr_q  <= '0;
      pc_id_q  <= '0;
      npc_id_q <= '0;
      nop_q    <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      npc_q    <= npc_d;
      instr_q  <= instr_d;
      pc_id_q  <= pc_id_d;
      npc_id_q <= npc_id_d;
      nop_q    <= nop_d;
      cnt_q    <= cnt_d;
    end
  end

  assign imem_addr = pc_q;
  assign instr_id  = instr_q;
  assign pc_id     = pc_id_q;
  assign npc_id    = npc_id_q;
  assign nop_id    = nop_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a cycle model pushes expected outputs to a scoreboard,
// popped after each edge; directed constant checks cover the listed fetch scenarios.
module tb_if_id_stage;

  localparam int          AW    = 32;
  localparam int          IW    = 32;
  localparam int          CW    = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic          clk;
  logic          reset;
  logic          stall;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic          annul;
  logic [IW-1:0] imem_data;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] instr_id;
  logic [AW-1:0] pc_id;
  logic [AW-1:0] npc_id;
  logic          nop_id;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pcid;
    logic [31:0] npcid;
    logic        nop;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0] m_pc, m_npc, m_instr, m_pcid, m_npcid;
  logic        m_nop, m_boot;
  logic [3:0]  m_cnt;

  if_id_stage #(
    .ADDR_W  (AW),
    .INSTR_W (IW),
    .RESET_PC(RPC),
    .CNT_W   (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .br_taken (br_taken),
    .br_target(br_target),
    .annul    (annul),
    .imem_data(imem_data),
    .imem_addr(imem_addr),
    .instr_id (instr_id),
    .pc_id    (pc_id),
    .npc_id   (npc_id),
    .nop_id   (nop_id),
    .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[17:2], a[17:2]} ^ 32'h1234_5678;
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    exp_t e;
    if (!reset) begin
      m_pc = RPC; m_npc = RPC + 32'd4;
      m_instr = '0; m_pcid = '0; m_npcid = '0; m_nop = 1'b1;
      m_cnt = '0; m_boot = 1'b1;
    end else if (m_boot) begin
      m_instr = '0; m_pcid = '0; m_npcid = '0; m_nop = 1'b1;
      m_boot = 1'b0;
    end else if (stall) begin
      if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
    end else begin
      m_pcid  = m_pc;
      m_npcid = m_npc;
      m_instr = annul ? 32'h0 : mem_word(m_pc);
      m_nop   = annul;
      m_pc    = m_npc;
      m_npc   = br_taken ? br_target : m_npc + 32'd4;
    end
    e.addr = m_pc; e.instr = m_instr; e.pcid = m_pcid;
    e.npcid = m_npcid; e.nop = m_nop; e.cnt = m_cnt;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("sb_imem_addr", imem_addr, e.addr);
      chk("sb_instr_id", instr_id, e.instr);
      chk("sb_pc_id", pc_id, e.pcid);
      chk("sb_npc_id", npc_id, e.npcid);
      chk("sb_nop_id", {31'b0, nop_id}, {31'b0, e.nop});
      chk("sb_stall_cnt", {28'b0, stall_cnt}, {28'b0, e.cnt});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0; annul = 1'b0;
    m_pc = '0; m_npc = '0; m_instr = '0; m_pcid = '0; m_npcid = '0;
    m_nop = 1'b1; m_boot = 1'b1; m_cnt = '0;
    #2;

    // T1: reset, BOOT, first fetch
    step(); step();
    chk("t1_rst_nop", {31'b0, nop_id}, 32'd1);
    chk("t1_rst_addr", imem_addr, 32'h0);
    reset = 1'b1;
    step();
    chk("t1_boot_addr", imem_addr, 32'h0);
    chk("t1_boot_nop", {31'b0, nop_id}, 32'd1);
    step();
    chk("t1_instr", instr_id, mem_word(32'h0));
    chk("t1_pc_id", pc_id, 32'h0);
    chk("t1_npc_id", npc_id, 32'h4);
    chk("t1_nop", {31'b0, nop_id}, 32'd0);
    chk("t1_addr", imem_addr, 32'h4);
    repeat (3) step();
    chk("t2_pre_addr", imem_addr, 32'h10);

    // T2: three-cycle stall at 0x10
    stall = 1'b1;
    repeat (3) step();
    chk("t2_stall_addr", imem_addr, 32'h10);
    chk("t2_stall_pc_id", pc_id, 32'hC);
    chk("t2_stall_cnt", {28'b0, stall_cnt}, 32'd3);
    stall = 1'b0;
    step();
    chk("t2_resume_addr", imem_addr, 32'h14);
    repeat (3) step();
    chk("t3_pre_addr", imem_addr, 32'h20);

    // T3: taken branch with delay slot
    br_taken = 1'b1; br_target = 32'h100;
    step();
    chk("t3_delay_addr", imem_addr, 32'h24);
    br_taken = 1'b0;
    step();
    chk("t3_target_addr", imem_addr, 32'h100);
    step();
    chk("t3_seq_addr", imem_addr, 32'h104);

    // T4: return to 0x20, then branch with annul
    br_taken = 1'b1; br_target = 32'h20;
    step();
    br_taken = 1'b0;
    step();
    chk("t4_pre_addr", imem_addr, 32'h20);
    br_taken = 1'b1; annul = 1'b1; br_target = 32'h100;
    step();
    chk("t4_nop", {31'b0, nop_id}, 32'd1);
    chk("t4_instr", instr_id, 32'h0);
    chk("t4_pc_id", pc_id, 32'h20);
    chk("t4_delay_addr", imem_addr, 32'h24);
    br_taken = 1'b0; annul = 1'b0;
    step();
    chk("t4_target_addr", imem_addr, 32'h100);
    chk("t4_slot_pc_id", pc_id, 32'h24);
    chk("t4_slot_nop", {31'b0, nop_id}, 32'd0);

    // T5: stall and branch together
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h200;
    step();
    chk("t5_stall_addr", imem_addr, 32'h100);
    chk("t5_cnt", {28'b0, stall_cnt}, 32'd4);
    stall = 1'b0;
    step();
    chk("t5_delay_addr", imem_addr, 32'h104);
    br_taken = 1'b0;
    step();
    chk("t5_target_addr", imem_addr, 32'h200);
    step();
    chk("t5_seq_addr", imem_addr, 32'h204);

    // T7: nPC wrap past all-ones
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    step();
    br_taken = 1'b0;
    step();
    chk("t7_top_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("t7_wrap_addr", imem_addr, 32'h0);
    chk("t7_wrap_pc_id", pc_id, 32'hFFFF_FFFC);
    chk("t7_wrap_npc_id", npc_id, 32'h0);

    // T6: reset during stall with a pending redirect
    reset = 1'b0;
    step();
    reset = 1'b1; stall = 1'b1;
    step();
    chk("t6_boot_cnt", {28'b0, stall_cnt}, 32'd0);
    chk("t6_boot_addr", imem_addr, 32'h0);
    repeat (5) step();
    chk("t6_pre_cnt", {28'b0, stall_cnt}, 32'd5);
    reset = 1'b0; br_taken = 1'b1; br_target = 32'h300;
    step();
    chk("t6_rst_addr", imem_addr, RPC);
    chk("t6_rst_cnt", {28'b0, stall_cnt}, 32'd0);
    chk("t6_rst_nop", {31'b0, nop_id}, 32'd1);
    reset = 1'b1; br_taken = 1'b0;
    step();
    chk("t6_boot2_cnt", {28'b0, stall_cnt}, 32'd0);

    // T8: counter saturation
    repeat (20) step();
    chk("t8_sat_cnt", {28'b0, stall_cnt}, 32'hF);
    step();
    chk("t8_hold_cnt", {28'b0, stall_cnt}, 32'hF);
    stall = 1'b0;
    step();
    chk("t8_after_cnt", {28'b0, stall_cnt}, 32'hF);
    chk("t8_after_addr", imem_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
